// File: rtl/fir_out_buffer.sv
// Output stage of the FIR filter: scales, rounds and saturates each accumulator
// result to 8 bits, then buffers the samples in a show-ahead FIFO for downstream.
module fir_out_buffer #(
    parameter int DEPTH = 4,
    parameter int SHIFT = 7,
    parameter int ROUND = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] acc_in,
    input  logic        acc_strobe,
    input  logic        clr_ovf,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic [4:0]  level,
    output logic        overflow,
    output logic        sat_seen
);

    localparam int          PW      = $clog2(DEPTH);
    localparam logic [4:0]  DEPTH_L = 5'(DEPTH);
    localparam logic [16:0] RND     = (ROUND != 0) ? (17'd1 << (SHIFT - 1)) : 17'd0;

    logic [15:0]   accData_q;
    logic          s1Valid_q;
    logic [7:0]    s2Data_q;
    logic          s2Valid_q;

    logic [16:0]   roundSum;
    logic [16:0]   scaledWide;
    logic          clip;
    logic [7:0]    scaled;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wrPtr_q;
    logic [PW-1:0] rdPtr_q;
    logic [4:0]    level_q;
    logic [4:0]    level_d;
    logic [7:0]    lastData_q;
    logic          ovf_q;
    logic          ovf_d;
    logic          sat_q;
    logic          sat_d;

    logic          full;
    logic          pop;
    logic          doPush;
    logic          drop;

    // 17-bit sum so the rounding offset can never wrap a large accumulator value
    always_comb begin
        roundSum   = {1'b0, accData_q} + RND;
        scaledWide = roundSum >> SHIFT;
        clip       = (scaledWide > 17'd255);
        scaled     = clip ? 8'hFF : scaledWide[7:0];
    end

    always_comb begin
        full    = (level_q == DEPTH_L);
        pop     = (level_q != 5'd0) && out_ready;
        doPush  = s2Valid_q && (!full || pop);
        drop    = s2Valid_q && full && !pop;
        level_d = level_q;
        if (doPush && !pop) begin
            level_d = level_q + 5'd1;
        end else if (!doPush && pop) begin
            level_d = level_q - 5'd1;
        end
        // A set event in the same cycle as a clear leaves the flag set
        ovf_d = drop || (ovf_q && !clr_ovf);
        sat_d = (s1Valid_q && clip) || (sat_q && !clr_ovf);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            accData_q  <= '0;
            s1Valid_q  <= 1'b0;
            s2Data_q   <= '0;
            s2Valid_q  <= 1'b0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            lastData_q <= '0;
            ovf_q      <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            if (acc_strobe) begin
                accData_q <= acc_in;
            end
            s1Valid_q <= acc_strobe;
            s2Valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                s2Data_q <= scaled;
            end
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_q    <= rdPtr_q + PW'(1);
                lastData_q <= mem_q[rdPtr_q];
            end
            level_q <= level_d;
            ovf_q   <= ovf_d;
            sat_q   <= sat_d;
        end
    end

    // Storage is not reset; the exact level count guards every read
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= s2Data_q;
        end
    end

    // When empty, out_data keeps showing the last sample that was popped
    assign out_valid = (level_q != 5'd0);
    assign out_data  = out_valid ? mem_q[rdPtr_q] : lastData_q;
    assign level     = level_q;
    assign overflow  = ovf_q;
    assign sat_seen  = sat_q;

endmodule

// File: tb/tb_fir_out_buffer.sv
// Directed bench for fir_out_buffer: a cycle-by-cycle vector table plus
// hand-written sequences for full-FIFO streaming, mid-stream reset and truncation.
module tb_fir_out_buffer;

    logic        clk;
    logic        reset;
    logic [15:0] acc_in;
    logic        acc_strobe;
    logic        clr_ovf;
    logic        out_ready;

    logic [7:0]  out_data;
    logic        out_valid;
    logic [4:0]  level;
    logic        overflow;
    logic        sat_seen;

    logic [7:0]  tOutData;
    logic        tOutValid;
    logic [4:0]  tLevel;
    logic        tOverflow;
    logic        tSatSeen;

    int checks;
    int failures;

    typedef struct {
        logic        strobe;
        logic [15:0] acc;
        logic        ready;
        logic        clr;
        logic        valid;
        logic [7:0]  data;
        logic [4:0]  lvl;
        logic        ovf;
        logic        sat;
    } vec_t;

    vec_t vecs [27];

    fir_out_buffer #(.DEPTH(4), .SHIFT(7), .ROUND(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .acc_in     (acc_in),
        .acc_strobe (acc_strobe),
        .clr_ovf    (clr_ovf),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .level      (level),
        .overflow   (overflow),
        .sat_seen   (sat_seen)
    );

    fir_out_buffer #(.DEPTH(4), .SHIFT(7), .ROUND(0)) dutTrunc (
        .clk        (clk),
        .reset      (reset),
        .acc_in     (acc_in),
        .acc_strobe (acc_strobe),
        .clr_ovf    (clr_ovf),
        .out_ready  (out_ready),
        .out_data   (tOutData),
        .out_valid  (tOutValid),
        .level      (tLevel),
        .overflow   (tOverflow),
        .sat_seen   (tSatSeen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic s, input logic [15:0] a, input logic r, input logic c);
        acc_strobe = s;
        acc_in     = a;
        out_ready  = r;
        clr_ovf    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b0;
        acc_in     = '0;
        acc_strobe = 1'b0;
        clr_ovf    = 1'b0;
        out_ready  = 1'b0;

        // strobe, acc, ready, clr | valid, data, level, overflow, sat_seen
        vecs[0]  = '{1'b1, 16'h0100, 1'b1, 1'b0, 1'b0, 8'd0,   5'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 16'h00C0, 1'b1, 1'b0, 1'b0, 8'd0,   5'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 16'h3FBF, 1'b1, 1'b0, 1'b1, 8'd2,   5'd1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd2,   5'd2, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd2,   5'd3, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'd2,   5'd2, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'd127, 5'd1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'd127, 5'd0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 16'h8000, 1'b1, 1'b0, 1'b0, 8'd127, 5'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 8'd127, 5'd0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'd255, 5'd1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'd255, 5'd1, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'd255, 5'd0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd255, 5'd0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 16'h0080, 1'b0, 1'b0, 1'b0, 8'd255, 5'd0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 8'd255, 5'd0, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 16'h0180, 1'b0, 1'b0, 1'b1, 8'd1,   5'd1, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 16'h0200, 1'b0, 1'b0, 1'b1, 8'd1,   5'd2, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 16'h0280, 1'b0, 1'b0, 1'b1, 8'd1,   5'd3, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 16'h0300, 1'b0, 1'b0, 1'b1, 8'd1,   5'd4, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd1,   5'd4, 1'b1, 1'b0};
        vecs[21] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 8'd1,   5'd4, 1'b1, 1'b0};
        vecs[22] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'd2,   5'd3, 1'b1, 1'b0};
        vecs[23] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'd3,   5'd2, 1'b1, 1'b0};
        vecs[24] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'd4,   5'd1, 1'b1, 1'b0};
        vecs[25] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'd4,   5'd0, 1'b1, 1'b0};
        vecs[26] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd4,   5'd0, 1'b0, 1'b0};

        #2;
        checkOutput("reset_valid", int'(out_valid), 0);
        checkOutput("reset_data", int'(out_data), 0);
        checkOutput("reset_level", int'(level), 0);
        checkOutput("reset_ovf", int'(overflow), 0);
        checkOutput("reset_sat", int'(sat_seen), 0);
        #1;
        reset = 1'b1;

        $display("[TB] vector table");
        for (int i = 0; i < 27; i++) begin
            applyStimulus(vecs[i].strobe, vecs[i].acc, vecs[i].ready, vecs[i].clr);
            checkOutput($sformatf("vec%0d_valid", i), int'(out_valid), int'(vecs[i].valid));
            checkOutput($sformatf("vec%0d_data", i), int'(out_data), int'(vecs[i].data));
            checkOutput($sformatf("vec%0d_level", i), int'(level), int'(vecs[i].lvl));
            checkOutput($sformatf("vec%0d_ovf", i), int'(overflow), int'(vecs[i].ovf));
            checkOutput($sformatf("vec%0d_sat", i), int'(sat_seen), int'(vecs[i].sat));
        end

        $display("[TB] full FIFO with simultaneous push and pop");
        for (int t = 0; t < 18; t++) begin
            applyStimulus(t < 12, 16'((10 + t) * 128), t >= 6, 1'b0);
            if (t < 2) begin
                checkOutput($sformatf("full%0d_valid", t), int'(out_valid), 0);
            end else if (t <= 5) begin
                checkOutput($sformatf("full%0d_level", t), int'(level), t - 1);
                checkOutput($sformatf("full%0d_data", t), int'(out_data), 10);
            end else if (t <= 13) begin
                checkOutput($sformatf("full%0d_level", t), int'(level), 4);
                checkOutput($sformatf("full%0d_data", t), int'(out_data), 5 + t);
                checkOutput($sformatf("full%0d_ovf", t), int'(overflow), 0);
            end else if (t <= 16) begin
                checkOutput($sformatf("full%0d_level", t), int'(level), 17 - t);
                checkOutput($sformatf("full%0d_data", t), int'(out_data), 5 + t);
            end else begin
                checkOutput($sformatf("full%0d_valid", t), int'(out_valid), 0);
                checkOutput($sformatf("full%0d_data", t), int'(out_data), 21);
            end
        end

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 16'h0080, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0100, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h8000, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0200, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("mid_level_before", int'(level), 3);
        checkOutput("mid_sat_before", int'(sat_seen), 1);
        reset = 1'b0;
        #1;
        checkOutput("mid_valid", int'(out_valid), 0);
        checkOutput("mid_data", int'(out_data), 0);
        checkOutput("mid_level", int'(level), 0);
        checkOutput("mid_ovf", int'(overflow), 0);
        checkOutput("mid_sat", int'(sat_seen), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(1'b1, 16'h0080, 1'b0, 1'b0);
        checkOutput("post_edge0_valid", int'(out_valid), 0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("post_edge1_valid", int'(out_valid), 0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("post_edge2_valid", int'(out_valid), 1);
        checkOutput("post_edge2_data", int'(out_data), 1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        end
        checkOutput("post_no_ghost_level", int'(level), 1);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("post_drain_level", int'(level), 0);

        $display("[TB] truncate mode");
        reset = 1'b0;
        #2;
        reset = 1'b1;
        applyStimulus(1'b1, 16'h00FF, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h7FFF, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("trunc_first_data", int'(tOutData), 1);
        checkOutput("trunc_first_level", int'(tLevel), 1);
        checkOutput("round_first_data", int'(out_data), 2);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("trunc_level2", int'(tLevel), 2);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("trunc_second_data", int'(tOutData), 255);
        checkOutput("trunc_sat", int'(tSatSeen), 0);
        checkOutput("round_second_data", int'(out_data), 255);
        checkOutput("round_sat", int'(sat_seen), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
